// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
// Shared constants for the CORDIC result word and the X/Y rounding helper.
//   Packed word layout: {mode[48], x[47:32], y[31:16], z[15:0]}
//   round_sat(v, out_w): rounds a signed FIELD_W value to out_w bits (round
//   half up) and saturates it. The result is returned sign-extended to
//   FIELD_W bits, so the caller keeps the low out_w bits.
// ---------------------------------------------------------------------------
package cordic_pkg;

    localparam int FIELD_W     = 16;
    localparam int TOTAL_WIDTH = 3 * FIELD_W + 1;
    localparam int MODE_BIT    = 3 * FIELD_W;
    localparam int X_LSB       = 2 * FIELD_W;
    localparam int Y_LSB       = FIELD_W;
    localparam int Z_LSB       = 0;

    function automatic logic [FIELD_W-1:0] round_sat(input logic [FIELD_W-1:0] v,
                                                     input int               out_w);
        logic signed [FIELD_W:0] ext;
        logic signed [FIELD_W:0] hi;
        logic signed [FIELD_W:0] lo;
        int                      sh;
        sh  = FIELD_W - out_w;
        // One guard bit keeps the +half addition from wrapping at the top.
        ext = $signed({v[FIELD_W-1], v});
        if (sh > 0) begin
            ext = ext + $signed((FIELD_W + 1)'(1) << (sh - 1));
        end
        ext = ext >>> sh;
        hi  = $signed((FIELD_W + 1)'((1 << (out_w - 1)) - 1));
        lo  = ~hi;  // -(hi) - 1
        if (ext > hi) begin
            ext = hi;
        end else if (ext < lo) begin
            ext = lo;
        end
        return ext[FIELD_W-1:0];
    endfunction

endpackage

// File: rtl/cordic_sync_fifo.sv
// ---------------------------------------------------------------------------
// cordic_sync_fifo
// Single-clock first-word-fall-through FIFO. Head entry is visible on
// rd_data_o whenever empty_o is low. Full/empty come from the occupancy count.
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   wr_en_i, wr_data_i  write request; accepted unless full without a pop
//   rd_en_i             pop request; ignored while empty
//   rd_data_o           head entry
//   count_o             occupancy 0..DEPTH
//   empty_o, full_o     status
// ---------------------------------------------------------------------------
module cordic_sync_fifo #(
    parameter int  WIDTH = 41,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_ok;
    logic             rd_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign rd_ok     = rd_en_i && !empty_o;
    // When full, a same-edge pop frees the slot the write lands in.
    assign wr_ok     = wr_en_i && (!full_o || rd_ok);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read while count is zero.
    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/cordic_out_buf.sv
// ---------------------------------------------------------------------------
// cordic_out_buf
// Captures every CORDIC result (the producer cannot stall), rounds and
// saturates X/Y to OUT_W, buffers results in a FIFO and offers them to the
// consumer. Results arriving while the FIFO is full and not popping are
// dropped and flagged on a sticky overflow bit.
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_vld, i_data    result strobe and packed word from cordic_top
//   i_rdy            consumer ready
//   i_ovf_clr        synchronous clear of o_ovf (a same-edge drop wins)
//   o_vld            head entry valid
//   o_mode,o_x,o_y,o_z  head entry fields (last popped values while o_vld=0)
//   o_cnt            FIFO occupancy 0..DEPTH
//   o_ovf            sticky "a result was dropped"
// Handshake: a transfer happens on every rising edge where o_vld and i_rdy
// are both high; o_vld never depends on i_rdy, and the head fields stay
// stable while o_vld=1 and i_rdy=0. i_rdy is ignored while o_vld=0.
// ---------------------------------------------------------------------------
module cordic_out_buf #(
    parameter int  TOTAL_WIDTH = 49,
    parameter int  FIELD_W     = 16,
    parameter int  OUT_W       = 12,
    parameter int  DEPTH       = 8,
    localparam int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_vld,
    input  logic [TOTAL_WIDTH-1:0] i_data,
    input  logic                   i_rdy,
    input  logic                   i_ovf_clr,
    output logic                   o_vld,
    output logic                   o_mode,
    output logic [OUT_W-1:0]       o_x,
    output logic [OUT_W-1:0]       o_y,
    output logic [FIELD_W-1:0]     o_z,
    output logic [CNT_W-1:0]       o_cnt,
    output logic                   o_ovf
);

    import cordic_pkg::*;

    // Buffered entry: {mode, x, y, z}
    localparam int EW = 1 + 2 * OUT_W + FIELD_W;

    logic [OUT_W-1:0] x_rnd;
    logic [OUT_W-1:0] y_rnd;
    logic             stage_vld_q, stage_vld_d;
    logic [EW-1:0]    stage_word_q, stage_word_d;
    logic             ovf_q, ovf_d;
    logic [EW-1:0]    hold_q, hold_d;
    logic [EW-1:0]    head;
    logic [EW-1:0]    out_word;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             drop;

    assign x_rnd = OUT_W'(round_sat(i_data[X_LSB +: FIELD_W], OUT_W));
    assign y_rnd = OUT_W'(round_sat(i_data[Y_LSB +: FIELD_W], OUT_W));

    assign pop  = !fifo_empty && i_rdy;
    assign drop = stage_vld_q && fifo_full && !pop;

    always_comb begin
        stage_vld_d  = i_vld;
        stage_word_d = stage_word_q;
        if (i_vld) begin
            stage_word_d = {i_data[MODE_BIT], x_rnd, y_rnd, i_data[Z_LSB +: FIELD_W]};
        end
        // Set has priority over clear so a coinciding drop is never lost.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end
        hold_d = pop ? head : hold_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage_vld_q  <= 1'b0;
            stage_word_q <= '0;
            ovf_q        <= 1'b0;
            hold_q       <= '0;
        end else begin
            stage_vld_q  <= stage_vld_d;
            stage_word_q <= stage_word_d;
            ovf_q        <= ovf_d;
            hold_q       <= hold_d;
        end
    end

    cordic_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .wr_en_i   (stage_vld_q),
        .wr_data_i (stage_word_q),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .count_o   (o_cnt),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    assign o_vld    = !fifo_empty;
    assign o_ovf    = ovf_q;
    // Idle outputs show the last popped entry (zero after reset).
    assign out_word = o_vld ? head : hold_q;
    assign o_mode   = out_word[EW-1];
    assign o_x      = out_word[EW-2 -: OUT_W];
    assign o_y      = out_word[FIELD_W +: OUT_W];
    assign o_z      = out_word[FIELD_W-1:0];

endmodule

// File: tb/tb_cordic_out_buf.sv
module tb_cordic_out_buf;

  logic        clk;
  logic        rst_n;
  logic        vld;
  logic [48:0] data;
  logic        rdy;
  logic        clr;
  logic        o_vld;
  logic        o_mode;
  logic [11:0] o_x;
  logic [11:0] o_y;
  logic [15:0] o_z;
  logic [3:0]  o_cnt;
  logic        o_ovf;

  int n_vec;
  int n_err;

  // reference model state: queue of buffered entries {mode,x,y,z}
  logic [40:0] mq[$];
  logic        m_sv;
  logic [40:0] m_sw;
  logic        m_ovf;
  logic [40:0] m_last;

  logic [46:0] obs;
  assign obs = {o_vld, o_cnt, o_ovf, o_mode, o_x, o_y, o_z};

  cordic_out_buf dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_vld     (vld),
    .i_data    (data),
    .i_rdy     (rdy),
    .i_ovf_clr (clr),
    .o_vld     (o_vld),
    .o_mode    (o_mode),
    .o_x       (o_x),
    .o_y       (o_y),
    .o_z       (o_z),
    .o_cnt     (o_cnt),
    .o_ovf     (o_ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // round half up to 12 bits then clamp, in plain integer arithmetic
  function automatic logic [11:0] m_round(input logic [15:0] v);
    int s;
    int r;
    s = int'($signed(v));
    r = (s + 8) >>> 4;
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
    return r[11:0];
  endfunction

  function automatic logic [40:0] m_pack(input logic [48:0] d);
    return {d[48], m_round(d[47:32]), m_round(d[31:16]), d[15:0]};
  endfunction

  function automatic logic [46:0] exp_obs();
    logic [40:0] h;
    h = (mq.size() != 0) ? mq[0] : m_last;
    return {mq.size() != 0, 4'(mq.size()), m_ovf, h};
  endfunction

  function automatic logic [48:0] rnd_word();
    logic [48:0] d;
    d[31:0]  = $urandom();
    d[48:32] = 17'($urandom());
    return d;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_sv   = 1'b0;
    m_sw   = '0;
    m_ovf  = 1'b0;
    m_last = '0;
  endtask

  // driver: apply inputs for one clock, advance the model, stop at negedge
  task automatic cycle(input logic v, input logic [48:0] d, input logic r, input logic c);
    logic dropped;
    vld  = v;
    data = d;
    rdy  = r;
    clr  = c;
    @(posedge clk);
    dropped = 1'b0;
    if (mq.size() != 0 && r) m_last = mq.pop_front();
    if (m_sv) begin
      if (mq.size() < 8) mq.push_back(m_sw);
      else dropped = 1'b1;
    end
    if (dropped) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    m_sv = v;
    if (v) m_sw = m_pack(d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld = 1'b0; data = '0; rdy = 1'b0; clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if (obs !== 47'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    if (obs !== exp_obs()) begin
      n_err++;
      $display("FAIL reset_idle: got %h want %h", obs, exp_obs());
    end
  endtask

  task automatic test_basic();
    logic [48:0] d;
    d = {1'b0, 16'h4000, 16'hC000, 16'h1234};
    cycle(1'b1, d, 1'b1, 1'b0);
    n_vec++;
    if (o_vld !== 1'b0) begin
      n_err++;
      $display("FAIL basic_lat1: o_vld got %b want 0", o_vld);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    if ({o_vld, o_mode, o_x, o_y, o_z, o_cnt} !== {1'b1, 1'b0, 12'h400, 12'hC00, 16'h1234, 4'd1}) begin
      n_err++;
      $display("FAIL basic_head: got vld=%b mode=%b x=%h y=%h z=%h cnt=%0d", o_vld, o_mode, o_x, o_y, o_z, o_cnt);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    if ({o_vld, o_cnt} !== 5'd0 || obs !== exp_obs()) begin
      n_err++;
      $display("FAIL basic_pop: got %h want %h", obs, exp_obs());
    end
  endtask

  task automatic test_rounding();
    logic [15:0] xin [5];
    logic [11:0] xexp [5];
    logic [48:0] d;
    xin  = '{16'h0008, 16'hFFF8, 16'hFFF7, 16'h7FF8, 16'h8000};
    xexp = '{12'h001, 12'h000, 12'hFFF, 12'h7FF, 12'h800};
    for (int i = 0; i < 5; i++) begin
      d = rnd_word();
      d[47:32] = xin[i];
      cycle(1'b1, d, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_vec++;
      if (o_vld !== 1'b1 || o_x !== xexp[i]) begin
        n_err++;
        $display("FAIL round_x%0d: in %h got x=%h vld=%b want %h", i, xin[i], o_x, o_vld, xexp[i]);
      end
      n_vec++;
      if (obs !== exp_obs()) begin
        n_err++;
        $display("FAIL round_model%0d: got %h want %h", i, obs, exp_obs());
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_overflow();
    logic [48:0] d;
    for (int k = 1; k <= 9; k++) begin
      d = rnd_word();
      d[15:0] = 16'(k);
      cycle(1'b1, d, 1'b0, 1'b0);
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    n_vec++;
    if (o_cnt !== 4'd8 || o_ovf !== 1'b1 || obs !== exp_obs()) begin
      n_err++;
      $display("FAIL ovf_full: got cnt=%0d ovf=%b want cnt=8 ovf=1", o_cnt, o_ovf);
    end
    for (int k = 1; k <= 8; k++) begin
      n_vec++;
      if (o_vld !== 1'b1 || o_z !== 16'(k)) begin
        n_err++;
        $display("FAIL ovf_order%0d: got vld=%b z=%0d want z=%0d", k, o_vld, o_z, k);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    n_vec++;
    if (o_vld !== 1'b0 || obs !== exp_obs()) begin
      n_err++;
      $display("FAIL ovf_drained: got %h want %h", obs, exp_obs());
    end
  endtask

  task automatic test_ovf_clear();
    cycle(1'b0, '0, 1'b0, 1'b1);
    n_vec++;
    if (o_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL clr_plain: o_ovf got %b want 0", o_ovf);
    end
    for (int k = 0; k < 8; k++) cycle(1'b1, rnd_word(), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, rnd_word(), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    n_vec++;
    if (o_ovf !== 1'b1 || o_cnt !== 4'd8) begin
      n_err++;
      $display("FAIL clr_vs_drop: got ovf=%b cnt=%0d want ovf=1 cnt=8", o_ovf, o_cnt);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    n_vec++;
    if (o_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL clr_after: o_ovf got %b want 0", o_ovf);
    end
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_vec++;
      if (obs !== exp_obs()) begin
        n_err++;
        $display("FAIL clr_drain%0d: got %h want %h", k, obs, exp_obs());
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) cycle(1'b1, rnd_word(), 1'b0, 1'b0);
    cycle(1'b1, rnd_word(), 1'b0, 1'b0);
    n_vec++;
    if (o_cnt !== 4'd8) begin
      n_err++;
      $display("FAIL b2b_fill: o_cnt got %0d want 8", o_cnt);
    end
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, rnd_word(), 1'b1, 1'b0);
      n_vec++;
      if (o_cnt !== 4'd8 || o_ovf !== 1'b0 || obs !== exp_obs()) begin
        n_err++;
        $display("FAIL b2b_stream%0d: got %h want %h (cnt 8, ovf 0)", k, obs, exp_obs());
      end
    end
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_vec++;
      if (obs !== exp_obs()) begin
        n_err++;
        $display("FAIL b2b_drain%0d: got %h want %h", k, obs, exp_obs());
      end
    end
    n_vec++;
    if (o_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL b2b_empty: o_cnt got %0d want 0", o_cnt);
    end
  endtask

  task automatic test_random();
    logic v;
    logic r;
    logic c;
    for (int k = 0; k < 400; k++) begin
      v = 1'($urandom_range(0, 1));
      r = (k < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      cycle(v, rnd_word(), r, c);
      n_vec++;
      if (obs !== exp_obs()) begin
        n_err++;
        $display("FAIL random%0d: got %h want %h", k, obs, exp_obs());
      end
    end
  endtask

  task automatic test_midreset();
    logic [48:0] d;
    for (int k = 0; k < 10; k++) cycle(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) cycle(1'b1, rnd_word(), 1'b0, 1'b0);
    n_vec++;
    if (o_cnt !== 4'd5) begin
      n_err++;
      $display("FAIL mrst_pre: o_cnt got %0d want 5", o_cnt);
    end
    vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o_vld, o_cnt} !== 5'd0) begin
      n_err++;
      $display("FAIL mrst_async: got vld=%b cnt=%0d want 0", o_vld, o_cnt);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_vec++;
      if (o_vld !== 1'b0) begin
        n_err++;
        $display("FAIL mrst_quiet%0d: o_vld got %b want 0", k, o_vld);
      end
    end
    d = rnd_word();
    cycle(1'b1, d, 1'b1, 1'b0);
    n_vec++;
    if (o_vld !== 1'b0) begin
      n_err++;
      $display("FAIL mrst_lat1: o_vld got %b want 0", o_vld);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    if (o_vld !== 1'b1 || o_cnt !== 4'd1 || o_z !== d[15:0] || obs !== exp_obs()) begin
      n_err++;
      $display("FAIL mrst_new: got %h want %h", obs, exp_obs());
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_ovf_clear();
    test_back_to_back();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
